// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial WIDTH-bit subtractor, diff = a - b - bin, computed LSB first,
//   one full-subtract step per clock. The borrow is carried in a flop between
//   bits. Upstream uses a start/busy/done handshake. Results stay registered
//   for the downstream consumer until the next completion.
//
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   start : request, sampled only while not busy (IDLE or DONE)
//   a, b  : minuend / subtrahend, captured on an accepted start
//   bin   : borrow-in, captured on an accepted start
//   busy  : high while bits are being processed
//   done  : one-cycle pulse when diff/bout carry a new result
//   diff  : registered difference, held until the next completion
//   bout  : registered final borrow-out, held until the next completion
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d;
  logic             cell_bo;

  // 1-bit full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic dd;
    logic bo;
    dd = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
    return {bo, dd};
  endfunction

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    {cell_bo, cell_d} = full_sub(a_sh_q[0], b_sh_q[0], br_q);

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start too, so back-to-back operations cost WIDTH+1 cycles.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        br_d   = cell_bo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the result including this cycle's MSB.
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bo;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      br_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, LSB first, one full-subtract cell per clock.
- The borrow is held in a flip-flop between bits.
- Sits directly around the team's 1-bit full-subtractor cell. The cell equations are inlined here so the block stands alone.
- Provides a start/busy/done handshake to the upstream controller, with registered results held for the downstream consumer.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend; captured on an accepted start
- b  input  WIDTH  subtrahend; captured on an accepted start
- bin  input  1  borrow-in; captured on an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when a result is ready
- diff  output  WIDTH  registered difference; holds until the next completion
- bout  output  1  registered final borrow-out; holds until the next completion

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Shift registers, borrow flop and bit counter cleared.
  - Takes effect immediately, including mid-operation. The operation in flight is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 at edge E:
  - Capture a, b into shift registers and bin into the borrow flop; count=0; go to RUN.
  - diff and bout are not changed at this edge.
- IDLE with start=0: remain in IDLE. DONE with start=0: return to IDLE.
- RUN, each edge, with a0 = LSB of the a shift register, b0 = LSB of the b shift register, br = borrow flop:
  - d = a0 ^ b0 ^ br
  - bo = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the MSB of the result shift register; shift both operand registers right one place.
  - br <= bo; count <= count + 1.
- Completion, on the edge where count == WIDTH-1:
  - diff <= completed result (the final d occupies the MSB).
  - bout <= bo.
  - Go to DONE.
- Timing relative to the start edge E:
  - busy=1 for exactly WIDTH cycles, edges E through E+WIDTH.
  - busy=0 and done=1 for the single cycle after edge E+WIDTH.
- start while busy (RUN): ignored entirely; the operation is not restarted and the new operands are not captured.
- start during the DONE cycle: accepted. This allows back-to-back operations with one done cycle between them, a throughput of WIDTH+1 cycles per result.
- Arithmetic: modulo 2^WIDTH. bout=1 iff a < b + bin as unsigned integers. The case a=b=all-ones with bin=1 gives diff=all-ones and bout=1.
- diff and bout change only at completion or reset. They are stable during RUN and while idle.
- Counter width is clog2(WIDTH). It is reset to 0 on every accepted start, with no wrap-around hazard.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic subtract, WIDTH=8: a=0x5A, b=0x3C, bin=0, pulse start → busy high 8 cycles, then done=1 for one cycle with diff=0x1E, bout=0.
- Underflow: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x00, b=0xFF, bin=1 → diff=0x00, bout=1.
- Borrow-in ripple: a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0. Check the result appears exactly 8 cycles after the start edge.
- Start ignored while busy: start a=0x80, b=0x01; at cycle 3 assert start with a=0xFF, b=0xFF → single done, diff=0x7F, bout=0, and busy is not extended.
- Back-to-back: hold start=1 continuously with a=0x05, b=0x03, then a=0x03, b=0x05 → done pulses 9 cycles apart; diff=0x02/bout=0, then diff=0xFE/bout=1. diff holds 0x02 throughout the second RUN.
- Reset mid-operation: assert rst at cycle 4 of a run → busy, done, diff, bout all 0 immediately. No done follows. A new start after reset produces a correct result.
